seg_scan_decoder: RTL and testbench

Monitors the multiplexed 7-segment scan bus (led_en/led_cx) produced by the display controller and reconstructs the 32-bit hex value being shown. It acts as the receiving end of the display scan interface. It is used for loopback self-check on the board and as a scoreboard front-end in simulation. It assembles one digit per scan slot, flags undecodable patterns, and reports complete frames plus a blank-display condition.

---
 rtl/seg_scan_decoder_pkg.sv | 39 +++
 rtl/seg_scan_decoder_pattern_decode.sv | 23 ++
 rtl/seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan interface: glyph table,
// drive polarities and the stability FSM state type.
package seg_scan_decoder_pkg;

    // Both digit enables and segment lines are active-low on the board.
    localparam logic LED_EN_ON = 1'b0;
    localparam logic LED_CX_ON = 1'b0;

    // Bus value with no digit enabled / no segment lit.
    localparam logic [7:0] LED_EN_ALL_OFF = 8'hFF;
    localparam logic [7:0] LED_CX_ALL_OFF = 8'hFF;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g}; index = hex digit.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_STABLE = 2'd1,
        ST_SAMPLED     = 2'd2
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_pattern_decode.sv
// Combinational segment-pattern to hex-nibble decoder; any pattern that is
// not one of the 16 glyphs decodes to nibble 0 with the error flag set.
module seg_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_err
);

    // Search the shared glyph table; glyphs are unique so at most one hits.
    always_comb begin
        o_nibble = 4'd0;
        o_err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == SEG_GLYPH[i]) begin
                o_nibble = 4'(i);
                o_err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiving end of the multiplexed 7-segment scan bus: samples each digit
// slot once it has been stable, assembles an 8-digit frame and detects a
// fully dark display.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int BLANK_TIMEOUT = 1_000_000,
    parameter int CNT_W         = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_en,
    input  logic [7:0]  led_cx,
    output logic [31:0] display_value,
    output logic [7:0]  digit_err,
    output logic        frame_valid,
    output logic        blank,
    output state_t      dbg_state
);

    logic [7:0]       r_en;
    logic [7:0]       r_en_prev;
    logic [7:0]       r_cx;
    logic [CNT_W-1:0] r_cnt_stable;
    logic [CNT_W-1:0] r_cnt_blank;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0][3:0]  r_shadow;
    logic [7:0]       r_shadow_err;
    logic [7:0]       r_captured;
    logic [31:0]      r_display_value;
    logic [7:0]       r_digit_err;
    logic             r_frame_valid;

    logic             w_en_same;
    logic             w_stable_hit;
    logic             w_sample;
    logic [7:0]       w_en_act;
    logic             w_slot_valid;
    logic [2:0]       w_slot;
    logic [3:0]       w_nibble;
    logic             w_dec_err;
    logic             w_dark;
    logic             w_blank;

    assign w_en_same    = (r_en == r_en_prev);
    assign w_stable_hit = (r_cnt_stable >= CNT_W'(STABLE_CYCLES - 1));
    assign w_en_act     = (LED_EN_ON == 1'b0) ? ~r_en : r_en;
    assign w_slot_valid = $onehot(w_en_act);
    assign w_dark       = (r_en == LED_EN_ALL_OFF) || (r_cx == LED_CX_ALL_OFF);
    assign w_blank      = (r_cnt_blank >= CNT_W'(BLANK_TIMEOUT));

    // Register the scan bus once; every later stage works on these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= LED_EN_ALL_OFF;
            r_en_prev <= LED_EN_ALL_OFF;
            r_cx      <= LED_CX_ALL_OFF;
        end else begin
            r_en      <= led_en;
            r_en_prev <= r_en;
            r_cx      <= led_cx;
        end
    end

    // Saturating run-length of unchanged led_en and of dark cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_stable <= '0;
            r_cnt_blank  <= '0;
        end else begin
            if (!w_en_same)
                r_cnt_stable <= '0;
            else if (r_cnt_stable != '1)
                r_cnt_stable <= r_cnt_stable + 1'b1;

            if (!w_dark)
                r_cnt_blank <= '0;
            else if (r_cnt_blank != '1)
                r_cnt_blank <= r_cnt_blank + 1'b1;
        end
    end

    // Index of the single active digit select (meaningful only when valid).
    always_comb begin
        w_slot = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_en_act[i])
                w_slot = 3'(i);
        end
    end

    seg_pattern_decode u_decode (
        .i_pattern (r_cx[7:1]),
        .o_nibble  (w_nibble),
        .o_err     (w_dec_err)
    );

    // Stability FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Stability FSM next state: one sample per stable led_en value.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:        w_state_nxt = ST_WAIT_STABLE;
            ST_WAIT_STABLE: begin
                if (!w_en_same)
                    w_state_nxt = ST_WAIT_STABLE;
                else if (w_stable_hit)
                    w_state_nxt = ST_SAMPLED;
            end
            ST_SAMPLED: begin
                if (!w_en_same)
                    w_state_nxt = ST_WAIT_STABLE;
            end
            default:        w_state_nxt = ST_IDLE;
        endcase
    end

    // Stability FSM output: sample strobe, suppressed for off/glitch slots.
    always_comb begin
        w_sample = 1'b0;
        if (r_state == ST_WAIT_STABLE && w_en_same && w_stable_hit && w_slot_valid)
            w_sample = 1'b1;
    end

    // Shadow capture and frame hand-off; a sample coinciding with frame
    // completion lands in the next frame because captured is rebuilt from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow        <= '0;
            r_shadow_err    <= '0;
            r_captured      <= '0;
            r_display_value <= '0;
            r_digit_err     <= '0;
            r_frame_valid   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_sample) begin
                r_shadow[w_slot]     <= w_nibble;
                r_shadow_err[w_slot] <= w_dec_err;
            end
            if (w_blank) begin
                r_captured <= '0;
            end else if (r_captured == 8'hFF) begin
                r_display_value <= r_shadow;
                r_digit_err     <= r_shadow_err;
                r_frame_valid   <= 1'b1;
                r_captured      <= w_sample ? (8'd1 << w_slot) : 8'd0;
            end else if (w_sample) begin
                r_captured[w_slot] <= 1'b1;
            end
        end
    end

    assign display_value = r_display_value;
    assign digit_err     = r_digit_err;
    assign frame_valid   = r_frame_valid;
    assign blank         = w_blank;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hex values over the 7-segment
// bus and checks reconstructed frames, error flags, glitch handling, blank
// detection and mid-frame reset.
module tb_seg_scan_decoder;
    import seg_scan_decoder_pkg::*;

    localparam int STABLE_CYCLES = 16;
    localparam int BLANK_TIMEOUT = 50;
    localparam int CNT_W         = 20;
    localparam int HOLD          = 100;

    logic        clk;
    logic        rst;
    logic [7:0]  led_en;
    logic [7:0]  led_cx;
    logic [31:0] display_value;
    logic [7:0]  digit_err;
    logic        frame_valid;
    logic        blank;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    int fv_count = 0;

    seg_scan_decoder #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .BLANK_TIMEOUT (BLANK_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .led_en        (led_en),
        .led_cx        (led_cx),
        .display_value (display_value),
        .digit_err     (digit_err),
        .frame_valid   (frame_valid),
        .blank         (blank),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_valid pulses mid-cycle.
    always @(negedge clk) begin
        if (frame_valid === 1'b1)
            fv_count++;
    end

    // Independent glyph table, active-low {a..g}.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    // Driver: light one slot with a pattern for a number of cycles.
    task automatic drive_slot(input int idx, input logic [6:0] pat, input int cycles);
        led_en      = 8'hFF;
        led_en[idx] = 1'b0;
        led_cx      = {pat, 1'b1};
        repeat (cycles) @(negedge clk);
    endtask

    // Driver: scan slots hi down to lo showing the nibbles of v.
    task automatic scan_value(input logic [31:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--)
            drive_slot(i, glyph(v[i*4 +: 4]), HOLD);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        led_en = 8'hFF;
        led_cx = 8'hFF;
        repeat (3) @(negedge clk);
        total++; if (display_value !== 32'h0) begin bad++; $display("FAIL reset_value: got %h want %h", display_value, 32'h0); end
        total++; if (digit_err !== 8'h0) begin bad++; $display("FAIL reset_err: got %h want %h", digit_err, 8'h0); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL reset_blank: got %b want 0", blank); end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int c0;
        c0 = fv_count;
        scan_value(32'h81050317, 7, 1);
        total++; if (fv_count !== c0) begin bad++; $display("FAIL basic_early_frame: got %0d want %0d", fv_count, c0); end
        scan_value(32'h81050317, 0, 0);
        total++; if (fv_count !== c0 + 1) begin bad++; $display("FAIL basic_frame_count: got %0d want %0d", fv_count, c0 + 1); end
        total++; if (display_value !== 32'h81050317) begin bad++; $display("FAIL basic_value: got %h want %h", display_value, 32'h81050317); end
        total++; if (digit_err !== 8'h00) begin bad++; $display("FAIL basic_err: got %h want %h", digit_err, 8'h00); end
    endtask

    task automatic test_bad_glyph();
        int c0;
        c0 = fv_count;
        scan_value(32'h12345678, 7, 4);
        drive_slot(3, 7'b1111110, HOLD);
        scan_value(32'h12345678, 2, 0);
        total++; if (fv_count !== c0 + 1) begin bad++; $display("FAIL badglyph_count: got %0d want %0d", fv_count, c0 + 1); end
        total++; if (display_value !== 32'h12340678) begin bad++; $display("FAIL badglyph_value: got %h want %h", display_value, 32'h12340678); end
        total++; if (digit_err !== 8'h08) begin bad++; $display("FAIL badglyph_err: got %h want %h", digit_err, 8'h08); end
    endtask

    task automatic test_fast_scan();
        int c0;
        c0 = fv_count;
        for (int k = 1; k <= 16; k++)
            drive_slot(k % 8, glyph(4'hF), 10);
        total++; if (fv_count !== c0) begin bad++; $display("FAIL fast_count: got %0d want %0d", fv_count, c0); end
        total++; if (display_value !== 32'h12340678) begin bad++; $display("FAIL fast_value: got %h want %h", display_value, 32'h12340678); end
        total++; if (digit_err !== 8'h08) begin bad++; $display("FAIL fast_err: got %h want %h", digit_err, 8'h08); end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = fv_count;
        scan_value(32'hFEDCBA98, 7, 4);
        led_en = 8'b11110011;
        led_cx = {glyph(4'h8), 1'b1};
        repeat (200) @(negedge clk);
        scan_value(32'hFEDCBA98, 3, 0);
        total++; if (fv_count !== c0 + 1) begin bad++; $display("FAIL glitch_count: got %0d want %0d", fv_count, c0 + 1); end
        total++; if (display_value !== 32'hFEDCBA98) begin bad++; $display("FAIL glitch_value: got %h want %h", display_value, 32'hFEDCBA98); end
        total++; if (digit_err !== 8'h00) begin bad++; $display("FAIL glitch_err: got %h want %h", digit_err, 8'h00); end
    endtask

    task automatic test_blank();
        int c0;
        c0 = fv_count;
        // Partial frame that the blank period must discard.
        scan_value(32'h2468ACE0, 7, 4);
        led_en = 8'hFF;
        led_cx = 8'hFF;
        repeat (45) @(negedge clk);
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL blank_early: got %b want 0", blank); end
        repeat (10) @(negedge clk);
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL blank_rise: got %b want 1", blank); end
        total++; if (display_value !== 32'hFEDCBA98) begin bad++; $display("FAIL blank_hold: got %h want %h", display_value, 32'hFEDCBA98); end
        drive_slot(3, glyph(4'hA), 3);
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL blank_fall: got %b want 0", blank); end
        drive_slot(3, glyph(4'hA), HOLD - 3);
        scan_value(32'h2468ACE0, 2, 0);
        total++; if (fv_count !== c0) begin bad++; $display("FAIL blank_discard: got %0d want %0d", fv_count, c0); end
        scan_value(32'h2468ACE0, 7, 4);
        total++; if (fv_count !== c0 + 1) begin bad++; $display("FAIL blank_frame_count: got %0d want %0d", fv_count, c0 + 1); end
        total++; if (display_value !== 32'h2468ACE0) begin bad++; $display("FAIL blank_frame_value: got %h want %h", display_value, 32'h2468ACE0); end
    endtask

    task automatic test_mid_reset();
        int c0;
        scan_value(32'h5A5A5A5A, 7, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (display_value !== 32'h0) begin bad++; $display("FAIL midrst_value: got %h want %h", display_value, 32'h0); end
        total++; if (digit_err !== 8'h0) begin bad++; $display("FAIL midrst_err: got %h want %h", digit_err, 8'h0); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_fv: got %b want 0", frame_valid); end
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL midrst_blank: got %b want 0", blank); end
        c0 = fv_count;
        scan_value(32'h13579BDF, 2, 0);
        total++; if (fv_count !== c0) begin bad++; $display("FAIL midrst_partial: got %0d want %0d", fv_count, c0); end
        scan_value(32'h13579BDF, 7, 3);
        total++; if (fv_count !== c0 + 1) begin bad++; $display("FAIL midrst_frame_count: got %0d want %0d", fv_count, c0 + 1); end
        total++; if (display_value !== 32'h13579BDF) begin bad++; $display("FAIL midrst_frame_value: got %h want %h", display_value, 32'h13579BDF); end
    endtask

    initial begin
        rst    = 1'b1;
        led_en = 8'hFF;
        led_cx = 8'hFF;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_bad_glyph();
        test_fast_scan();
        test_glitch();
        test_blank();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
